// File: rtl/seq_det_pkg.sv
// Shared helpers for the programmable serial pattern detector: width derivation
// and the supported pattern-length range.
package seq_det_pkg;

   localparam int SEQ_LEN_MIN = 2;
   localparam int SEQ_LEN_MAX = 16;

   function automatic int sd_clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Width needed to hold a match length in 0..seq_len.
   function automatic int sl_width(input int seq_len);
      return sd_clog2(seq_len + 1);
   endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational next-state for the pattern detector: longest suffix of
// (matched prefix, new bit) that is also a pattern prefix, or a restart in non-overlap mode.
module seq_det_next
   import seq_det_pkg::*;
#(
   parameter int SEQ_LEN = 3,
   parameter int SL_W    = sl_width(SEQ_LEN)
) (
   input  logic [SEQ_LEN-1:0] pattern_i,
   input  logic [SL_W-1:0]    k_i,
   input  logic               b_i,
   input  logic               overlap_i,
   output logic [SL_W-1:0]    next_o
);

   // Bit number 'pos' in arrival order; position 0 is the pattern MSB.
   function automatic logic prefix_bit(input logic [SEQ_LEN-1:0] p, input int pos);
      logic [SEQ_LEN-1:0] t;
      t = p >> (SEQ_LEN - 1 - pos);
      return t[0];
   endfunction

   always_comb begin
      int  k;
      int  best;
      int  idx;
      logic ok;
      k    = int'(k_i);
      best = 0;
      idx  = 0;
      ok   = 1'b0;
      if (k == SEQ_LEN && !overlap_i) begin
         best = (b_i == pattern_i[SEQ_LEN-1]) ? 1 : 0;
      end else begin
         // Candidate length L keeps the last L-1 matched bits plus the new bit.
         for (int len = 1; len <= SEQ_LEN; len++) begin
            ok = (len <= k + 1);
            for (int i = 0; i < SEQ_LEN - 1; i++) begin
               if (ok && (i < len - 1)) begin
                  idx = k + 1 - len + i;
                  if (prefix_bit(pattern_i, idx) != prefix_bit(pattern_i, i)) ok = 1'b0;
               end
            end
            if (ok && (b_i != prefix_bit(pattern_i, len - 1))) ok = 1'b0;
            if (ok) best = len;
         end
      end
      next_o = best[SL_W-1:0];
   end

endmodule

// File: rtl/seq_det_prog.sv
// Run-time programmable Moore serial pattern detector with overlap control.
// Define SEQ_DET_CNT_EN to build the saturating detection counter; otherwise o_det_cnt is 0.
module seq_det_prog
   import seq_det_pkg::*;
#(
   parameter int                 SEQ_LEN     = 3,
   parameter logic [SEQ_LEN-1:0] RST_PATTERN = SEQ_LEN'(3'b101),
   parameter int                 CNT_W       = 8,
   localparam int                SL_W        = sl_width(SEQ_LEN)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_enable,
   input  logic               i_seq,
   input  logic               i_overlap,
   input  logic               i_load,
   input  logic [SEQ_LEN-1:0] i_pattern,
   output logic               o_detect,
   output logic [SL_W-1:0]    o_match_len,
   output logic [CNT_W-1:0]   o_det_cnt
);

   localparam logic [SL_W-1:0] FULL = SL_W'(SEQ_LEN);

   generate
      if (SEQ_LEN < SEQ_LEN_MIN || SEQ_LEN > SEQ_LEN_MAX) begin : g_bad_len
         $error("seq_det_prog: SEQ_LEN out of range");
      end
   endgenerate

   logic [SEQ_LEN-1:0] pattern_q, pattern_d;
   logic [SL_W-1:0]    state_q, state_d;
   logic [SL_W-1:0]    next_state;
   logic               detect_q, detect_d;

   seq_det_next #(
      .SEQ_LEN (SEQ_LEN),
      .SL_W    (SL_W)
   ) u_next (
      .pattern_i (pattern_q),
      .k_i       (state_q),
      .b_i       (i_seq),
      .overlap_i (i_overlap),
      .next_o    (next_state)
   );

   // Load wins over enable and discards that edge's stream bit.
   always_comb begin
      pattern_d = pattern_q;
      state_d   = state_q;
      detect_d  = detect_q;
      if (i_load) begin
         pattern_d = i_pattern;
         state_d   = '0;
         detect_d  = 1'b0;
      end else if (i_enable) begin
         state_d  = next_state;
         detect_d = (next_state == FULL);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pattern_q <= RST_PATTERN;
         state_q   <= '0;
         detect_q  <= 1'b0;
      end else begin
         pattern_q <= pattern_d;
         state_q   <= state_d;
         detect_q  <= detect_d;
      end
   end

   assign o_detect    = detect_q;
   assign o_match_len = state_q;

`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturates at all-ones rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = '0;
      end else if (i_enable && (next_state == FULL) && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign o_det_cnt = cnt_q;
`else
   assign o_det_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Scoreboard bench for seq_det_prog: three instances (default, 2-bit counter,
// 5-bit pattern) share control inputs and are compared against a history-based model.
module tb_seq_det_prog;

   logic       clk;
   logic       rst;
   logic       en;
   logic       seq;
   logic       ovl;
   logic       ld;
   logic [2:0] pat3;
   logic [4:0] pat5;

   logic       det0, det1, det2;
   logic [1:0] ml0, ml1;
   logic [2:0] ml2;
   logic [7:0] cnt0, cnt2;
   logic [1:0] cnt1;

   seq_det_prog dut (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_seq(seq), .i_overlap(ovl),
      .i_load(ld), .i_pattern(pat3), .o_detect(det0), .o_match_len(ml0), .o_det_cnt(cnt0)
   );

   seq_det_prog #(.CNT_W(2)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_seq(seq), .i_overlap(ovl),
      .i_load(ld), .i_pattern(pat3), .o_detect(det1), .o_match_len(ml1), .o_det_cnt(cnt1)
   );

   seq_det_prog #(.SEQ_LEN(5), .RST_PATTERN(5'b10110)) dut5 (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_seq(seq), .i_overlap(ovl),
      .i_load(ld), .i_pattern(pat5), .o_detect(det2), .o_match_len(ml2), .o_det_cnt(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] s0, s1, s2;
      logic [31:0] c0, c1, c2;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   int          mlen[3] = '{3, 3, 5};
   int          mmax[3] = '{255, 3, 255};
   logic [15:0] mpat[3];
   logic [31:0] mhist[3];
   int          mhlen[3];
   int          mst[3];
   int          mcnt[3];

   task automatic model_reset();
      for (int n = 0; n < 3; n++) begin
         mpat[n]  = (n == 2) ? 16'b10110 : 16'b101;
         mhist[n] = '0;
         mhlen[n] = 0;
         mst[n]   = 0;
         mcnt[n]  = 0;
      end
   endtask

   task automatic model_apply(input bit e, input bit b, input bit o, input bit l);
      int  best;
      bit  ok;
      for (int n = 0; n < 3; n++) begin
         if (l) begin
            mpat[n]  = (n == 2) ? {11'b0, pat5} : {13'b0, pat3};
            mhist[n] = '0;
            mhlen[n] = 0;
            mst[n]   = 0;
            mcnt[n]  = 0;
         end else if (e) begin
            if (mst[n] == mlen[n] && !o) begin
               mhist[n] = '0;
               mhlen[n] = 0;
            end
            mhist[n] = {mhist[n][30:0], b};
            if (mhlen[n] < 32) mhlen[n]++;
            best = 0;
            for (int len = 1; len <= mlen[n]; len++) begin
               if (len <= mhlen[n]) begin
                  ok = 1'b1;
                  for (int i = 0; i < len; i++)
                     if (mhist[n][len-1-i] != mpat[n][mlen[n]-1-i]) ok = 1'b0;
                  if (ok) best = len;
               end
            end
            mst[n] = best;
            if (best == mlen[n] && mcnt[n] < mmax[n]) mcnt[n]++;
         end
      end
   endtask

   function automatic logic [31:0] ecnt(input int n);
`ifdef SEQ_DET_CNT_EN
      return mcnt[n];
`else
      return 0;
`endif
   endfunction

   task automatic drive(input bit e, input bit b, input bit o, input bit l);
      exp_t x;
      en = e; seq = b; ovl = o; ld = l;
      model_apply(e, b, o, l);
      x.s0 = mst[0]; x.s1 = mst[1]; x.s2 = mst[2];
      x.c0 = ecnt(0); x.c1 = ecnt(1); x.c2 = ecnt(2);
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; seq = 1'b0; ovl = 1'b1; ld = 1'b0; pat3 = '0; pat5 = '0;
      model_reset();
      #3;
      checks += 4;
      if (ml0 !== 2'd0)  begin failures++; $display("FAIL reset_len got=%0d exp=0", ml0); end
      if (det0 !== 1'b0) begin failures++; $display("FAIL reset_det got=%0b exp=0", det0); end
      if (cnt0 !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt0); end
      if (ml2 !== 3'd0)  begin failures++; $display("FAIL reset_len5 got=%0d exp=0", ml2); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_overlap(input bit o, input logic [31:0] want_cnt);
      exp_t x;
      bit   stream[5] = '{1, 0, 1, 0, 1};
      pat3 = 3'b101; pat5 = 5'b10110;
      drive(1'b0, 1'b0, o, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, stream[i], o, 1'b0);
         x = sb.pop_front();
         checks += 3;
         if (32'(ml0) !== x.s0) begin failures++; $display("FAIL ovl%0b_len bit=%0d got=%0d exp=%0d", o, i+1, ml0, x.s0); end
         if (det0 !== (x.s0 == 3)) begin failures++; $display("FAIL ovl%0b_det bit=%0d got=%0b exp=%0b", o, i+1, det0, x.s0 == 3); end
         if (32'(cnt0) !== x.c0) begin failures++; $display("FAIL ovl%0b_cnt bit=%0d got=%0d exp=%0d", o, i+1, cnt0, x.c0); end
      end
      checks++;
      if (32'(cnt0) !== want_cnt) begin failures++; $display("FAIL ovl%0b_total got=%0d exp=%0d", o, cnt0, want_cnt); end
   endtask

   task automatic test_load_111(input bit o);
      exp_t x;
      pat3 = 3'b111; pat5 = 5'b11111;
      drive(1'b1, 1'b1, o, 1'b1);
      x = sb.pop_front();
      checks++;
      if (32'(ml0) !== x.s0) begin failures++; $display("FAIL load_clear got=%0d exp=%0d", ml0, x.s0); end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, o, 1'b0);
         x = sb.pop_front();
         checks += 3;
         if (32'(ml0) !== x.s0) begin failures++; $display("FAIL p111_ovl%0b_len bit=%0d got=%0d exp=%0d", o, i+1, ml0, x.s0); end
         if (det0 !== (x.s0 == 3)) begin failures++; $display("FAIL p111_ovl%0b_det bit=%0d got=%0b exp=%0b", o, i+1, det0, x.s0 == 3); end
         if (32'(cnt0) !== x.c0) begin failures++; $display("FAIL p111_ovl%0b_cnt bit=%0d got=%0d exp=%0d", o, i+1, cnt0, x.c0); end
      end
   endtask

   task automatic test_enable_hold();
      exp_t x;
      pat3 = 3'b101; pat5 = 5'b10110;
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      void'(sb.pop_front());
      drive(1'b1, 1'b1, 1'b1, 1'b0); void'(sb.pop_front());
      drive(1'b1, 1'b0, 1'b1, 1'b0); void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, i[0], 1'b1, 1'b0);
         x = sb.pop_front();
         checks += 3;
         if (ml0 !== 2'd2) begin failures++; $display("FAIL hold_len cyc=%0d got=%0d exp=2", i, ml0); end
         if (32'(ml0) !== x.s0) begin failures++; $display("FAIL hold_model cyc=%0d got=%0d exp=%0d", i, ml0, x.s0); end
         if (det0 !== 1'b0) begin failures++; $display("FAIL hold_det cyc=%0d got=%0b exp=0", i, det0); end
      end
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      x = sb.pop_front();
      checks += 2;
      if (det0 !== 1'b1) begin failures++; $display("FAIL hold_final_det got=%0b exp=1", det0); end
      if (32'(cnt0) !== x.c0) begin failures++; $display("FAIL hold_final_cnt got=%0d exp=%0d", cnt0, x.c0); end
   endtask

   task automatic test_async_reset();
      exp_t x;
      drive(1'b1, 1'b1, 1'b1, 1'b0); void'(sb.pop_front());
      drive(1'b1, 1'b0, 1'b1, 1'b0); void'(sb.pop_front());
      checks++;
      if (ml0 !== 2'd2) begin failures++; $display("FAIL arst_pre got=%0d exp=2", ml0); end
      en = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks += 3;
      if (ml0 !== 2'd0)  begin failures++; $display("FAIL arst_len got=%0d exp=0", ml0); end
      if (det0 !== 1'b0) begin failures++; $display("FAIL arst_det got=%0b exp=0", det0); end
      if (cnt0 !== 8'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", cnt0); end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      x = sb.pop_front();
      checks += 2;
      if (ml0 !== 2'd1) begin failures++; $display("FAIL arst_after got=%0d exp=1", ml0); end
      if (32'(ml2) !== x.s2) begin failures++; $display("FAIL arst_after5 got=%0d exp=%0d", ml2, x.s2); end
   endtask

   task automatic test_saturate();
      exp_t x;
      logic [31:0] want;
      pat3 = 3'b101; pat5 = 5'b10110;
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, ~i[0], 1'b1, 1'b0);
         x = sb.pop_front();
         checks += 2;
         if (32'(cnt1) !== x.c1) begin failures++; $display("FAIL sat_cnt bit=%0d got=%0d exp=%0d", i+1, cnt1, x.c1); end
         if (det1 !== (x.s1 == 3)) begin failures++; $display("FAIL sat_det bit=%0d got=%0b exp=%0b", i+1, det1, x.s1 == 3); end
      end
`ifdef SEQ_DET_CNT_EN
      want = 3;
`else
      want = 0;
`endif
      checks++;
      if (32'(cnt1) !== want) begin failures++; $display("FAIL sat_final got=%0d exp=%0d", cnt1, want); end
   endtask

   task automatic test_random();
      exp_t x;
      bit   l;
      for (int i = 0; i < 400; i++) begin
         l = ($urandom_range(0, 24) == 0);
         if (l) begin
            pat3 = 3'($urandom_range(0, 7));
            pat5 = 5'($urandom_range(0, 31));
         end
         drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0, l);
         x = sb.pop_front();
         checks += 9;
         if (32'(ml0) !== x.s0) begin failures++; $display("FAIL rnd_len0 cyc=%0d got=%0d exp=%0d", i, ml0, x.s0); end
         if (32'(ml1) !== x.s1) begin failures++; $display("FAIL rnd_len1 cyc=%0d got=%0d exp=%0d", i, ml1, x.s1); end
         if (32'(ml2) !== x.s2) begin failures++; $display("FAIL rnd_len2 cyc=%0d got=%0d exp=%0d", i, ml2, x.s2); end
         if (det0 !== (x.s0 == 3)) begin failures++; $display("FAIL rnd_det0 cyc=%0d got=%0b", i, det0); end
         if (det1 !== (x.s1 == 3)) begin failures++; $display("FAIL rnd_det1 cyc=%0d got=%0b", i, det1); end
         if (det2 !== (x.s2 == 5)) begin failures++; $display("FAIL rnd_det2 cyc=%0d got=%0b", i, det2); end
         if (32'(cnt0) !== x.c0) begin failures++; $display("FAIL rnd_cnt0 cyc=%0d got=%0d exp=%0d", i, cnt0, x.c0); end
         if (32'(cnt1) !== x.c1) begin failures++; $display("FAIL rnd_cnt1 cyc=%0d got=%0d exp=%0d", i, cnt1, x.c1); end
         if (32'(cnt2) !== x.c2) begin failures++; $display("FAIL rnd_cnt2 cyc=%0d got=%0d exp=%0d", i, cnt2, x.c2); end
      end
   endtask

   initial begin
      test_reset();
`ifdef SEQ_DET_CNT_EN
      test_overlap(1'b1, 2);
      test_overlap(1'b0, 1);
`else
      test_overlap(1'b1, 0);
      test_overlap(1'b0, 0);
`endif
      test_load_111(1'b1);
      test_load_111(1'b0);
      test_enable_hold();
      test_async_reset();
      test_saturate();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
